// File: rtl/uartio_fifo.sv
// UART with TX/RX FIFOs on the 3-bit CPU bus; DO registered one clock after a read access.
// No bus backpressure: TX writes into a full FIFO are dropped (TOV), RX frames into a full FIFO are dropped (ROE).
module uartio_fifo #(
  parameter int          DATA_BITS       = 8,
  parameter int          FIFO_DEPTH      = 16,
  parameter logic [15:0] PRESCALER_RESET = 16'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       rxd,
  output logic       txd
);

  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic                 rd, wr;
  logic                 tie, rie, loop, rfe, roe, tov;
  logic [15:0]          prescaler, baud_cnt;
  logic [7:0]           thr, thr_eff, rx_cnt8, rd_dat;
  logic [6:0]           tx_cnt7;
  logic                 tick, riq, tiq, tov_set;
  logic                 rx_s1, rx_s2, rx_in;

  logic                 rx_push, rx_pop, rx_flush, rx_empty, rx_full, rx_ferr, rx_ovf, rx_last;
  logic [DATA_BITS-1:0] rx_head, rx_sh;
  logic [CW-1:0]        rx_count;
  logic [3:0]           rx_tcnt;
  logic [2:0]           rx_bcnt;
  uart_state_t          rx_state, rx_next;

  logic                 tx_push, tx_pop, tx_flush, tx_empty, tx_full, tx_avail, tx_last, tx_line;
  logic [DATA_BITS-1:0] tx_head, tx_sh;
  logic [CW-1:0]        tx_count;
  logic [3:0]           tx_tcnt;
  logic [2:0]           tx_bcnt;
  uart_state_t          tx_state, tx_next;

  assign rd       = cs & rw;
  assign wr       = cs & ~rw;
  assign rx_pop   = rd & (AD == 3'd0) & ~rx_empty;
  assign tx_push  = wr & (AD == 3'd0);
  assign rx_flush = wr & (AD == 3'd7) & DI[0];
  assign tx_flush = wr & (AD == 3'd7) & DI[1];

  uartio_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .flush(rx_flush), .push(rx_push), .pop(rx_pop),
    .wdat(rx_sh), .rdat(rx_head), .count(rx_count), .empty(rx_empty), .full(rx_full)
  );

  uartio_fifo_buf #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .flush(tx_flush), .push(tx_push), .pop(tx_pop),
    .wdat(DI[DATA_BITS-1:0]), .rdat(tx_head), .count(tx_count), .empty(tx_empty), .full(tx_full)
  );

  // Baud tick every prescaler+1 clocks; a new prescaler is picked up at the next reload.
  assign tick = (baud_cnt == 16'd0);
  always_ff @(posedge clk) begin
    if (rst)       baud_cnt <= PRESCALER_RESET;
    else if (tick) baud_cnt <= prescaler;
    else           baud_cnt <= baud_cnt - 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
    end
  end

  assign rx_in = loop ? tx_line : rx_s2;
  assign txd   = loop ? 1'b1 : tx_line;

  // ---------------- transmitter ----------------
  assign tx_last  = tick & (tx_tcnt == 4'd15);
  assign tx_avail = ~tx_empty & ~tx_flush;

  always_ff @(posedge clk) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      S_IDLE:  if (tx_avail) tx_next = S_START;
      S_START: if (tx_last) tx_next = S_DATA;
      S_DATA:  if (tx_last && tx_bcnt == LAST_BIT) tx_next = S_STOP;
      S_STOP:  if (tx_last) tx_next = tx_avail ? S_START : S_IDLE;
      default: tx_next = S_IDLE;
    endcase
  end

  // Popping at the end of the stop bit chains frames with no idle gap.
  always_comb begin
    tx_pop  = 1'b0;
    tx_line = 1'b1;
    case (tx_state)
      S_IDLE:  tx_pop  = tx_avail;
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tx_sh[0];
      S_STOP:  tx_pop  = tx_last & tx_avail;
      default: tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tcnt <= 4'd0;
      tx_bcnt <= 3'd0;
      tx_sh   <= '0;
    end else if (tx_pop) begin
      tx_sh   <= tx_head;
      tx_tcnt <= 4'd0;
      tx_bcnt <= 3'd0;
    end else if (tick && tx_state != S_IDLE) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_state == S_DATA && tx_tcnt == 4'd15) begin
        tx_sh   <= tx_sh >> 1;
        tx_bcnt <= tx_bcnt + 3'd1;
      end
    end
  end

  // ---------------- receiver ----------------
  assign rx_last = tick & (rx_tcnt == 4'd15);
  assign rx_ovf  = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge clk) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      S_IDLE:  if (tick && !rx_in) rx_next = S_START;
      S_START: if (tick && rx_tcnt == 4'd7) rx_next = rx_in ? S_IDLE : S_DATA;
      S_DATA:  if (rx_last && rx_bcnt == LAST_BIT) rx_next = S_STOP;
      S_STOP:  if (rx_last) rx_next = S_IDLE;
      default: rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    rx_push = 1'b0;
    rx_ferr = 1'b0;
    case (rx_state)
      S_STOP: begin
        rx_push = rx_last & rx_in;
        rx_ferr = rx_last & ~rx_in;
      end
      default: rx_push = 1'b0;
    endcase
  end

  // The start-bit re-sample at tick 8 puts every later sample mid-bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_tcnt <= 4'd0;
      rx_bcnt <= 3'd0;
      rx_sh   <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          rx_tcnt <= 4'd0;
          rx_bcnt <= 3'd0;
        end
        S_START: if (tick) rx_tcnt <= (rx_tcnt == 4'd7) ? 4'd0 : rx_tcnt + 4'd1;
        S_DATA: if (tick) begin
          rx_tcnt <= rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_sh   <= {rx_in, rx_sh[DATA_BITS-1:1]};
            rx_bcnt <= rx_bcnt + 3'd1;
          end
        end
        S_STOP: if (tick) rx_tcnt <= rx_tcnt + 4'd1;
        default: rx_tcnt <= 4'd0;
      endcase
    end
  end

  // ---------------- registers ----------------
  assign thr_eff = (thr == 8'd0) ? 8'd1 : thr;
  assign rx_cnt8 = 8'(rx_count);
  assign tx_cnt7 = 7'(tx_count);
  assign riq     = rie & (rx_cnt8 >= thr_eff);
  assign tiq     = tie & tx_empty & (tx_state == S_IDLE);
  assign tov_set = tx_push & tx_full & ~tx_pop;

  always_comb begin
    rd_dat = 8'd0;
    case (AD)
      3'd0: if (!rx_empty) rd_dat = 8'(rx_head);
      3'd1: rd_dat = {tiq, riq, tie, rie, ~tx_full, rfe, roe, ~rx_empty};
      3'd2: rd_dat = prescaler[15:8];
      3'd3: rd_dat = prescaler[7:0];
      3'd4: rd_dat = rx_cnt8;
      3'd5: rd_dat = {tov, tx_cnt7};
      3'd6: rd_dat = thr;
      3'd7: rd_dat = {5'd0, loop, 2'd0};
      default: rd_dat = 8'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tie       <= 1'b0;
      rie       <= 1'b0;
      loop      <= 1'b0;
      rfe       <= 1'b0;
      roe       <= 1'b0;
      tov       <= 1'b0;
      thr       <= 8'd1;
      prescaler <= PRESCALER_RESET;
      DO        <= 8'd0;
      irq       <= 1'b0;
    end else begin
      irq <= tiq | riq;
      if (rd) DO <= rd_dat;
      if (wr) begin
        case (AD)
          3'd1: begin
            tie <= DI[5];
            rie <= DI[4];
            if (DI[3]) tov <= 1'b0;
          end
          3'd2: prescaler[15:8] <= DI;
          3'd3: prescaler[7:0]  <= DI;
          3'd6: thr             <= DI;
          3'd7: loop            <= DI[2];
          default: ;
        endcase
      end
      if (rd && AD == 3'd1) begin
        rfe <= 1'b0;
        roe <= 1'b0;
      end
      // A new error landing on the clearing read stays visible for the next read.
      if (rx_ferr) rfe <= 1'b1;
      if (rx_ovf)  roe <= 1'b1;
      if (tov_set) tov <= 1'b1;
    end
  end

endmodule

// Synchronous FIFO: head visible combinationally; push+pop together always honoured, flush dominates.
module uartio_fifo_buf #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdat,
  output logic [W-1:0]           rdat,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int           AW       = $clog2(DEPTH);
  localparam logic [AW:0]  FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pass, do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // On an empty FIFO a simultaneous push and pop hands the word straight through.
  assign pass    = empty & push & pop;
  assign do_pop  = pop & ~empty;
  assign do_push = push & ~pass & (~full | do_pop);
  assign rdat    = empty ? wdat : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wptr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
